// File: rtl/nbiot_tx_pkg.sv
// Shared NB-IoT transmit-chain definitions: CRC generator polynomials and the
// two-state attach FSM encoding.
package nbiot_tx_pkg;

   localparam int          CRC_W       = 24;
   localparam logic [23:0] CRC24A_POLY = 24'h864CFB;
   localparam logic [23:0] CRC24B_POLY = 24'h800063;

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } attach_state_e;

endpackage

// File: rtl/crc24a_attach_if.sv
// Serial payload input and parallel block output of the CRC attach stage.
// blk_out is ascending [0:K-1] so index 0 carries a0, the first bit received.
interface crc24a_attach_if
   import nbiot_tx_pkg::*;
#(
   parameter int K = 40
);
   logic             bit_in;
   logic             bit_valid;
   logic             bit_ready;
   logic [0:K-1]     blk_out;
   logic             blk_valid;
   logic             blk_ack;
   logic [CRC_W-1:0] crc_out;

   modport master (
      output bit_in, bit_valid, blk_ack,
      input  bit_ready, blk_out, blk_valid, crc_out
   );

   modport slave (
      input  bit_in, bit_valid, blk_ack,
      output bit_ready, blk_out, blk_valid, crc_out
   );
endinterface

// File: rtl/crc24_lfsr.sv
// Bit-serial 24-bit CRC register, MSB-first, no reflection, zero init.
// crc_next is the value after absorbing din, exposed so callers can capture it same-cycle.
module crc24_lfsr
   import nbiot_tx_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC24A_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] crc,
   output logic [CRC_W-1:0] crc_next
);
   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;
   logic             fb;

   // clr wins over en so the final bit of a block can be absorbed and cleared together
   always_comb begin
      fb       = din ^ crc_q[CRC_W-1];
      crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      crc_d    = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = crc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;
endmodule

// File: rtl/crc24a_attach.sv
// Transport-block CRC-24A attachment: collects A = K-24 serial bits, then holds
// {payload, parity} as one K-bit word until the downstream acknowledges it.
module crc24a_attach
   import nbiot_tx_pkg::*;
#(
   parameter int               K    = 40,
   parameter logic [CRC_W-1:0] POLY = CRC24A_POLY
) (
   input  logic           clk,
   input  logic           rst,
   crc24a_attach_if.slave bus
);
   // A must be at least 2 so the held-payload register has a width
   localparam int A     = K - CRC_W;
   localparam int PAY_W = A - 1;
   localparam int CNT_W = (A > 1) ? $clog2(A) : 1;

   attach_state_e    state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PAY_W-1:0] payload_q, payload_d;
   logic [0:K-1]     blk_out_q, blk_out_d;
   logic             blk_valid_q, blk_valid_d;
   logic [CRC_W-1:0] crc_out_q, crc_out_d;

   logic             accept;
   logic             lfsr_clr;
   logic [CRC_W-1:0] lfsr_crc;
   logic [CRC_W-1:0] crc_next;

   crc24_lfsr #(.POLY(POLY)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .clr      (lfsr_clr),
      .en       (accept),
      .din      (bus.bit_in),
      .crc      (lfsr_crc),
      .crc_next (crc_next)
   );

   always_comb begin
      accept      = bus.bit_valid && (state_q == COLLECT);
      lfsr_clr    = 1'b0;
      state_d     = state_q;
      count_d     = count_q;
      payload_d   = payload_q;
      blk_out_d   = blk_out_q;
      blk_valid_d = blk_valid_q;
      crc_out_d   = crc_out_q;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               // only the first A-1 bits need holding; the last one goes straight to blk_out
               payload_d = PAY_W'({payload_q, bus.bit_in});
               if (count_q == CNT_W'(A - 1)) begin
                  count_d     = '0;
                  lfsr_clr    = 1'b1;
                  blk_out_d   = {payload_q, bus.bit_in, crc_next};
                  crc_out_d   = crc_next;
                  blk_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (blk_valid_q && bus.blk_ack) begin
               blk_valid_d = 1'b0;
               state_d     = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= COLLECT;
         count_q     <= '0;
         payload_q   <= '0;
         blk_out_q   <= '0;
         blk_valid_q <= 1'b0;
         crc_out_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         payload_q   <= payload_d;
         blk_out_q   <= blk_out_d;
         blk_valid_q <= blk_valid_d;
         crc_out_q   <= crc_out_d;
      end
   end

   assign bus.bit_ready = (state_q == COLLECT);
   assign bus.blk_out   = blk_out_q;
   assign bus.blk_valid = blk_valid_q;
   assign bus.crc_out   = crc_out_q;

   // the LFSR must already be cleared while a finished block waits for its ack
   a_lfsr_clear_in_done : assert property (
      @(posedge clk) disable iff (!rst) (state_q == DONE) |-> (lfsr_crc == '0)
   );
endmodule

// File: tb/tb_crc24a_attach.sv
// Randomized scoreboard bench for crc24a_attach: a polynomial-division CRC model
// predicts every block, a monitor compares on each new blk_valid.
module tb_crc24a_attach;
   import nbiot_tx_pkg::*;

   localparam int K   = 40;
   localparam int A   = K - CRC_W;
   localparam int K64 = 64;
   localparam int A64 = K64 - CRC_W;

   typedef struct {
      logic [39:0] blk;
      logic [23:0] crc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   crc24a_attach_if #(.K(K))   bus   ();
   crc24a_attach_if #(.K(K64)) bus64 ();

   crc24a_attach #(.K(K), .POLY(CRC24A_POLY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   crc24a_attach #(.K(K64), .POLY(CRC24A_POLY)) dut64 (
      .clk (clk),
      .rst (rst),
      .bus (bus64)
   );

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ack_hold = -1;
   int   ack_h;
   logic mon_prev;
   int   mon_nb;

   // Remainder of a(x)*x^24 divided by g(x) = x^24 + POLY, msg holds a0 at bit n-1
   function automatic logic [23:0] crc_model(input logic [63:0] msg, input int n);
      logic [87:0] rem;
      logic [87:0] gen;
      rem = 88'(msg) << 24;
      gen = {64'd0, CRC24A_POLY} | (88'd1 << 24);
      for (int i = n + 23; i >= 24; i--) begin
         if (rem[i]) rem = rem ^ (gen << (i - 24));
      end
      return rem[23:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Sends n bits (a0 first) on bus, bub = percent of bubble cycles
   task automatic send_block(input logic [63:0] bits, input int n, input int bub, input bit push);
      logic acc;
      int   wait_cyc;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         bus.bit_in = bits[n-1-i];
         acc        = 1'b0;
         wait_cyc   = 0;
         while (!acc) begin
            bus.bit_valid = ($urandom_range(99) >= bub);
            @(negedge clk);
            acc = bus.bit_valid && bus.bit_ready;
            if (acc && i == n - 1) begin
               check("valid_before_last_edge", 64'(bus.blk_valid), 64'd0);
               if (push) begin
                  e.crc = crc_model(bits, n);
                  e.blk = {bits[15:0], e.crc};
                  sb_q.push_back(e);
               end
            end
            @(posedge clk);
            #1;
            wait_cyc++;
            if (!acc && wait_cyc > 200) begin
               check("bit_accept_timeout", 64'd0, 64'd1);
               bus.bit_valid = 1'b0;
               return;
            end
         end
      end
      bus.bit_valid = 1'b0;
   endtask

   initial begin : monitor
      mon_prev = 1'b0;
      mon_nb   = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_prev = 1'b0;
         end else begin
            if (bus.blk_valid && !mon_prev) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_block", 64'd1, 64'd0);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check("blk_out", 64'(bus.blk_out), 64'(e.blk));
                  check("crc_out", 64'(bus.crc_out), 64'(e.crc));
                  $display("block %0d: blk_out=%h crc_out=%h", mon_nb, bus.blk_out, bus.crc_out);
               end
               mon_nb++;
            end
            mon_prev = bus.blk_valid;
         end
      end
   end

   // Downstream consumer: acks after ack_hold cycles (random when negative) and,
   // in random mode, throws in stray acks while no block is pending
   initial begin : acker
      bus.blk_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && bus.blk_valid && !bus.blk_ack) begin
            ack_h = (ack_hold < 0) ? int'($urandom_range(3)) : ack_hold;
            repeat (ack_h) @(posedge clk);
            #1 bus.blk_ack = 1'b1;
            @(posedge clk);
            #1 bus.blk_ack = 1'b0;
         end else if (rst && !bus.blk_valid && ack_hold < 0 && $urandom_range(9) == 0) begin
            bus.blk_ack = 1'b1;
            @(posedge clk);
            #1 bus.blk_ack = 1'b0;
         end
      end
   end

   initial begin : main
      logic [39:0] t2_blk;
      logic [63:0] p;
      logic [63:0] exp64;
      int          wait_cyc;
      int          i64, blk64, nblk64, guard;
      int          rise[2];
      logic        prev64;

      bus.bit_in      = 1'b0;
      bus.bit_valid   = 1'b0;
      bus64.bit_in    = 1'b0;
      bus64.bit_valid = 1'b0;
      bus64.blk_ack   = 1'b1;
      t2_blk          = {16'h0001, 24'h864CFB};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_blk_valid", 64'(bus.blk_valid), 64'd0);
      check("reset_blk_out", 64'(bus.blk_out), 64'd0);
      check("reset_crc_out", 64'(bus.crc_out), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("reset_bit_ready", 64'(bus.bit_ready), 64'd1);
      @(posedge clk);
      #1;

      // all-zero payload back-to-back, then the single-one payload
      send_block(64'd0, A, 0, 1'b1);
      @(negedge clk);
      check("latency_valid", 64'(bus.blk_valid), 64'd1);
      @(posedge clk);
      #1;
      send_block(64'd1, A, 0, 1'b1);

      for (int b = 0; b < 400; b++) begin
         p = 64'($urandom_range(32'hFFFF));
         send_block(p, A, int'($urandom_range(40)), 1'b1);
      end

      // long-held ack: outputs frozen and stray bit_valid ignored
      ack_hold = 10;
      send_block(64'd1, A, 50, 1'b1);
      for (int c = 0; c < 8; c++) begin
         bus.bit_valid = 1'($urandom_range(1));
         bus.bit_in    = 1'($urandom_range(1));
         @(negedge clk);
         check("done_bit_ready", 64'(bus.bit_ready), 64'd0);
         check("done_blk_valid", 64'(bus.blk_valid), 64'd1);
         check("done_blk_out", 64'(bus.blk_out), 64'(t2_blk));
         @(posedge clk);
         #1;
      end
      bus.bit_valid = 1'b0;
      wait_cyc = 0;
      do begin
         @(negedge clk);
         wait_cyc++;
      end while (bus.blk_valid && wait_cyc < 20);
      check("ack_clears_valid", 64'(bus.blk_valid), 64'd0);
      check("ready_after_ack", 64'(bus.bit_ready), 64'd1);
      check("blk_out_held", 64'(bus.blk_out), 64'(t2_blk));
      @(posedge clk);
      #1;
      ack_hold = -1;
      send_block(64'd1, A, 0, 1'b1);

      // reset after 9 bits, then a full block
      send_block(64'($urandom_range(32'h1FF)), 9, 0, 1'b0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midreset_blk_valid", 64'(bus.blk_valid), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      send_block(64'd1, A, 20, 1'b1);

      // K=64 instance, ack tied high, two back-to-back a39=1 blocks
      exp64  = {40'd1, crc_model(64'd1, A64)};
      i64    = 0;
      blk64  = 0;
      nblk64 = 0;
      guard  = 0;
      prev64 = 1'b0;
      while (nblk64 < 2 && guard < 300) begin
         bus64.bit_valid = (blk64 < 2);
         bus64.bit_in    = (i64 == A64 - 1);
         @(negedge clk);
         if (bus64.blk_valid && !prev64) begin
            rise[nblk64] = guard;
            check("k64_crc_out", 64'(bus64.crc_out), 64'(24'h864CFB));
            check("k64_blk_out", 64'(bus64.blk_out), exp64);
            $display("k64 block %0d: blk_out=%h crc_out=%h", nblk64, bus64.blk_out, bus64.crc_out);
            nblk64++;
         end
         prev64 = bus64.blk_valid;
         if (bus64.bit_valid && bus64.bit_ready) begin
            i64++;
            if (i64 == A64) begin
               i64 = 0;
               blk64++;
            end
         end
         @(posedge clk);
         #1;
         guard++;
      end
      bus64.bit_valid = 1'b0;
      check("k64_blocks_seen", 64'(nblk64), 64'd2);
      if (nblk64 == 2) check("k64_block_interval", 64'(rise[1] - rise[0]), 64'(A64 + 1));

      repeat (10) @(posedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
